// File: rtl/fifo_showahead_if.sv
// Request/flag bundle between a fifo_showahead instance and its producer/consumer.
// The master modport is the client side, and the slave modport is the FIFO side.
interface fifo_showahead_if #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 4
);
   logic [DWIDTH-1:0] data_i;
   logic              wrreq_i;
   logic              rdreq_i;
   logic [DWIDTH-1:0] q_o;
   logic              empty_o;
   logic              full_o;
   logic [AWIDTH:0]   usedw_o;
   logic              almost_full_o;
   logic              almost_empty_o;
   logic              ovf_o;
   logic              udf_o;

   modport master (
      output data_i, wrreq_i, rdreq_i,
      input  q_o, empty_o, full_o, usedw_o, almost_full_o, almost_empty_o, ovf_o, udf_o
   );

   modport slave (
      input  data_i, wrreq_i, rdreq_i,
      output q_o, empty_o, full_o, usedw_o, almost_full_o, almost_empty_o, ovf_o, udf_o
   );
endinterface

// File: rtl/fifo_showahead.sv
// Single-clock FIFO on a registered-read RAM with occupancy flags and optional show-ahead prefetch.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise ovf_o/udf_o are tied low.
module fifo_showahead #(
   parameter int DWIDTH             = 8,
   parameter int AWIDTH             = 4,
   parameter int SHOWAHEAD          = 1,
   parameter int ALMOST_FULL_VALUE  = 12,
   parameter int ALMOST_EMPTY_VALUE = 4
) (
   input logic             clk_i,
   input logic             rst_n_i,
   fifo_showahead_if.slave bus
);
   localparam int              DEPTH    = 2**AWIDTH;
   localparam logic [AWIDTH:0] FULL_LVL = (AWIDTH+1)'(DEPTH);
   localparam logic [AWIDTH:0] AF_LVL   = (AWIDTH+1)'(ALMOST_FULL_VALUE);
   localparam logic [AWIDTH:0] AE_LVL   = (AWIDTH+1)'(ALMOST_EMPTY_VALUE);
   localparam logic [AWIDTH:0] CNT_ONE  = (AWIDTH+1)'(1);
   localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_FETCH,
      ST_VALID
   } state_e;

   logic [DWIDTH-1:0] mem [DEPTH];

   logic [AWIDTH-1:0] wrptr_q, wrptr_d;
   logic [AWIDTH-1:0] rdptr_q, rdptr_d;
   logic [AWIDTH:0]   usedw_q, usedw_d;
   logic [DWIDTH-1:0] q_q, q_d;
   state_e            state_q, state_d;

   logic              empty;
   logic              full;
   logic              wr_accept;
   logic              rd_accept;
   logic              q_load;
   logic [AWIDTH-1:0] rd_addr;

   assign full      = (usedw_q == FULL_LVL);
   assign wr_accept = bus.wrreq_i && !full;
   assign rd_accept = bus.rdreq_i && !empty;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // A pop that leaves no stored word falls back to EMPTY so the next write re-primes through FETCH.
   always_comb begin
      state_d = state_q;
      if (SHOWAHEAD != 0) begin
         unique case (state_q)
            ST_EMPTY: if (usedw_q != '0) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_VALID;
            ST_VALID: if (rd_accept && (usedw_q == CNT_ONE)) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      empty   = 1'b1;
      q_load  = 1'b0;
      rd_addr = rdptr_q;
      if (SHOWAHEAD != 0) begin
         unique case (state_q)
            ST_EMPTY: q_load = (usedw_q != '0);
            ST_FETCH: q_load = 1'b0;
            ST_VALID: begin
               empty = 1'b0;
               if (bus.rdreq_i && (usedw_q > CNT_ONE)) begin
                  q_load  = 1'b1;
                  rd_addr = rdptr_q + PTR_ONE;
               end
            end
            default: empty = 1'b1;
         endcase
      end else begin
         empty  = (usedw_q == '0);
         q_load = bus.rdreq_i && (usedw_q != '0);
      end
   end

   always_comb begin
      wrptr_d = wr_accept ? (wrptr_q + PTR_ONE) : wrptr_q;
      rdptr_d = rd_accept ? (rdptr_q + PTR_ONE) : rdptr_q;
      usedw_d = usedw_q;
      unique case ({wr_accept, rd_accept})
         2'b10:   usedw_d = usedw_q + CNT_ONE;
         2'b01:   usedw_d = usedw_q - CNT_ONE;
         default: usedw_d = usedw_q;
      endcase
      q_d = q_load ? mem[rd_addr] : q_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wrptr_q <= '0;
         rdptr_q <= '0;
         usedw_q <= '0;
         q_q     <= '0;
      end else begin
         wrptr_q <= wrptr_d;
         rdptr_q <= rdptr_d;
         usedw_q <= usedw_d;
         q_q     <= q_d;
      end
   end

   // Storage is deliberately not reset; the write is gated so a write racing reset never lands.
   always_ff @(posedge clk_i) begin
      if (rst_n_i && wr_accept) begin
         mem[wrptr_q] <= bus.data_i;
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   always_comb begin
      ovf_d = ovf_q | (bus.wrreq_i & full);
      udf_d = udf_q | (bus.rdreq_i & empty);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign bus.ovf_o = ovf_q;
   assign bus.udf_o = udf_q;
`else
   assign bus.ovf_o = 1'b0;
   assign bus.udf_o = 1'b0;
`endif

   assign bus.q_o            = q_q;
   assign bus.empty_o        = empty;
   assign bus.full_o         = full;
   assign bus.usedw_o        = usedw_q;
   assign bus.almost_full_o  = (usedw_q >= AF_LVL);
   assign bus.almost_empty_o = (usedw_q < AE_LVL);
endmodule

// File: tb/tb_fifo_showahead.sv
// Directed bench for fifo_showahead: one normal-mode and one show-ahead instance on a shared clock/reset.
// Expected ovf_o/udf_o follow whether FIFO_ERR_FLAGS_EN is defined for the build.
module tb_fifo_showahead;
`ifdef FIFO_ERR_FLAGS_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   passed;
   int   total;

   fifo_showahead_if #(.DWIDTH(8), .AWIDTH(4)) bn_if ();
   fifo_showahead_if #(.DWIDTH(8), .AWIDTH(4)) bs_if ();

   fifo_showahead #(.DWIDTH(8), .AWIDTH(4), .SHOWAHEAD(0),
                    .ALMOST_FULL_VALUE(12), .ALMOST_EMPTY_VALUE(4)) u_norm (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bn_if.slave)
   );

   fifo_showahead #(.DWIDTH(8), .AWIDTH(4), .SHOWAHEAD(1),
                    .ALMOST_FULL_VALUE(12), .ALMOST_EMPTY_VALUE(4)) u_sa (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bs_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bn_if.data_i = '0; bn_if.wrreq_i = 1'b0; bn_if.rdreq_i = 1'b0;
      bs_if.data_i = '0; bs_if.wrreq_i = 1'b0; bs_if.rdreq_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (bn_if.usedw_o !== 5'd0) $display("[TB] FAIL reset norm usedw: got %0d, expected 0", bn_if.usedw_o); else passed++;
      total++; if (bn_if.q_o !== 8'h00) $display("[TB] FAIL reset norm q: got %h, expected 00", bn_if.q_o); else passed++;
      total++; if ({bn_if.empty_o, bn_if.full_o, bn_if.almost_empty_o, bn_if.almost_full_o, bn_if.ovf_o, bn_if.udf_o} !== 6'b101000)
         $display("[TB] FAIL reset norm flags: got %b, expected 101000", {bn_if.empty_o, bn_if.full_o, bn_if.almost_empty_o, bn_if.almost_full_o, bn_if.ovf_o, bn_if.udf_o});
      else passed++;
      total++; if (bs_if.usedw_o !== 5'd0) $display("[TB] FAIL reset sa usedw: got %0d, expected 0", bs_if.usedw_o); else passed++;
      total++; if (bs_if.q_o !== 8'h00) $display("[TB] FAIL reset sa q: got %h, expected 00", bs_if.q_o); else passed++;
      total++; if ({bs_if.empty_o, bs_if.full_o, bs_if.almost_empty_o, bs_if.almost_full_o, bs_if.ovf_o, bs_if.udf_o} !== 6'b101000)
         $display("[TB] FAIL reset sa flags: got %b, expected 101000", {bs_if.empty_o, bs_if.full_o, bs_if.almost_empty_o, bs_if.almost_full_o, bs_if.ovf_o, bs_if.udf_o});
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      total++; if (bn_if.empty_o !== 1'b1) $display("[TB] FAIL release norm empty: got %b, expected 1", bn_if.empty_o); else passed++;
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 16; i++) begin
         bn_if.data_i = 8'(i); bn_if.wrreq_i = 1'b1;
         cyc();
         total++; if (bn_if.usedw_o !== 5'(i + 1)) $display("[TB] FAIL fill usedw[%0d]: got %0d, expected %0d", i, bn_if.usedw_o, i + 1); else passed++;
         total++; if ({bn_if.full_o, bn_if.almost_full_o, bn_if.empty_o} !== {(i == 15), (i >= 11), 1'b0})
            $display("[TB] FAIL fill flags[%0d]: got %b, expected %b", i, {bn_if.full_o, bn_if.almost_full_o, bn_if.empty_o}, {(i == 15), (i >= 11), 1'b0});
         else passed++;
      end
      bn_if.wrreq_i = 1'b0;
      total++; if (bn_if.q_o !== 8'h00) $display("[TB] FAIL fill q before read: got %h, expected 00", bn_if.q_o); else passed++;
      for (int i = 0; i < 16; i++) begin
         bn_if.rdreq_i = 1'b1;
         cyc();
         total++; if (bn_if.q_o !== 8'(i)) $display("[TB] FAIL drain q[%0d]: got %h, expected %h", i, bn_if.q_o, 8'(i)); else passed++;
         total++; if (bn_if.usedw_o !== 5'(15 - i)) $display("[TB] FAIL drain usedw[%0d]: got %0d, expected %0d", i, bn_if.usedw_o, 15 - i); else passed++;
         total++; if ({bn_if.empty_o, bn_if.almost_empty_o} !== {(i == 15), ((15 - i) < 4)})
            $display("[TB] FAIL drain flags[%0d]: got %b, expected %b", i, {bn_if.empty_o, bn_if.almost_empty_o}, {(i == 15), ((15 - i) < 4)});
         else passed++;
      end
      bn_if.rdreq_i = 1'b0;
   endtask

   task automatic test_boundary();
      for (int i = 0; i < 16; i++) begin
         bn_if.data_i = 8'(8'h30 + i); bn_if.wrreq_i = 1'b1;
         cyc();
      end
      bn_if.data_i = 8'hEE;
      cyc();
      total++; if (bn_if.usedw_o !== 5'd16) $display("[TB] FAIL ovf usedw: got %0d, expected 16", bn_if.usedw_o); else passed++;
      total++; if (bn_if.ovf_o !== ERR_EN) $display("[TB] FAIL ovf flag: got %b, expected %b", bn_if.ovf_o, ERR_EN); else passed++;
      bn_if.wrreq_i = 1'b0;
      cyc();
      total++; if (bn_if.ovf_o !== ERR_EN) $display("[TB] FAIL ovf sticky: got %b, expected %b", bn_if.ovf_o, ERR_EN); else passed++;
      bn_if.data_i = 8'hDD; bn_if.wrreq_i = 1'b1; bn_if.rdreq_i = 1'b1;
      cyc();
      bn_if.wrreq_i = 1'b0; bn_if.rdreq_i = 1'b0;
      total++; if (bn_if.usedw_o !== 5'd15) $display("[TB] FAIL fullrw usedw: got %0d, expected 15", bn_if.usedw_o); else passed++;
      total++; if (bn_if.q_o !== 8'h30) $display("[TB] FAIL fullrw q: got %h, expected 30", bn_if.q_o); else passed++;
      for (int i = 0; i < 15; i++) begin
         bn_if.rdreq_i = 1'b1;
         cyc();
         total++; if (bn_if.q_o !== 8'(8'h31 + i)) $display("[TB] FAIL bdrain q[%0d]: got %h, expected %h", i, bn_if.q_o, 8'(8'h31 + i)); else passed++;
      end
      cyc();
      total++; if (bn_if.usedw_o !== 5'd0) $display("[TB] FAIL udf usedw: got %0d, expected 0", bn_if.usedw_o); else passed++;
      total++; if (bn_if.q_o !== 8'h3F) $display("[TB] FAIL udf q hold: got %h, expected 3f", bn_if.q_o); else passed++;
      total++; if (bn_if.udf_o !== ERR_EN) $display("[TB] FAIL udf flag: got %b, expected %b", bn_if.udf_o, ERR_EN); else passed++;
      bn_if.rdreq_i = 1'b0;
      cyc();
      total++; if ({bn_if.udf_o, bn_if.ovf_o, bn_if.empty_o} !== {ERR_EN, ERR_EN, 1'b1})
         $display("[TB] FAIL udf sticky: got %b, expected %b", {bn_if.udf_o, bn_if.ovf_o, bn_if.empty_o}, {ERR_EN, ERR_EN, 1'b1});
      else passed++;
   endtask

   task automatic test_showahead();
      bs_if.data_i = 8'hA5; bs_if.wrreq_i = 1'b1;
      cyc();
      bs_if.wrreq_i = 1'b0;
      total++; if ({bs_if.usedw_o, bs_if.empty_o} !== {5'd1, 1'b1}) $display("[TB] FAIL sa k usedw/empty: got %0d/%b, expected 1/1", bs_if.usedw_o, bs_if.empty_o); else passed++;
      cyc();
      total++; if (bs_if.empty_o !== 1'b1) $display("[TB] FAIL sa k+1 empty: got %b, expected 1", bs_if.empty_o); else passed++;
      cyc();
      total++; if (bs_if.empty_o !== 1'b0) $display("[TB] FAIL sa k+2 empty: got %b, expected 0", bs_if.empty_o); else passed++;
      total++; if (bs_if.q_o !== 8'hA5) $display("[TB] FAIL sa k+2 q: got %h, expected a5", bs_if.q_o); else passed++;
      bs_if.rdreq_i = 1'b1;
      cyc();
      bs_if.rdreq_i = 1'b0;
      total++; if ({bs_if.usedw_o, bs_if.empty_o} !== {5'd0, 1'b1}) $display("[TB] FAIL sa pop usedw/empty: got %0d/%b, expected 0/1", bs_if.usedw_o, bs_if.empty_o); else passed++;
      for (int i = 1; i <= 3; i++) begin
         bs_if.data_i = 8'(i); bs_if.wrreq_i = 1'b1;
         cyc();
      end
      bs_if.wrreq_i = 1'b0;
      total++; if ({bs_if.q_o, bs_if.empty_o} !== {8'h01, 1'b0}) $display("[TB] FAIL sa head: got %h/%b, expected 01/0", bs_if.q_o, bs_if.empty_o); else passed++;
      bs_if.rdreq_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc();
         total++; if ({bs_if.q_o, bs_if.usedw_o, bs_if.empty_o} !== {8'(i + 2), 5'(2 - i), 1'b0})
            $display("[TB] FAIL sa stream[%0d]: got %h/%0d/%b, expected %h/%0d/0", i, bs_if.q_o, bs_if.usedw_o, bs_if.empty_o, 8'(i + 2), 2 - i);
         else passed++;
      end
      cyc();
      bs_if.rdreq_i = 1'b0;
      total++; if ({bs_if.usedw_o, bs_if.empty_o, bs_if.udf_o} !== {5'd0, 1'b1, 1'b0})
         $display("[TB] FAIL sa stream end: got %0d/%b/%b, expected 0/1/0", bs_if.usedw_o, bs_if.empty_o, bs_if.udf_o);
      else passed++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 7; i++) begin
         bs_if.data_i = 8'(8'h10 + i); bs_if.wrreq_i = 1'b1;
         cyc();
      end
      total++; if ({bs_if.usedw_o, bs_if.q_o, bs_if.empty_o} !== {5'd7, 8'h10, 1'b0})
         $display("[TB] FAIL b2b start: got %0d/%h/%b, expected 7/10/0", bs_if.usedw_o, bs_if.q_o, bs_if.empty_o);
      else passed++;
      bs_if.rdreq_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bs_if.data_i = 8'(8'h17 + i);
         cyc();
         total++; if ({bs_if.usedw_o, bs_if.q_o} !== {5'd7, 8'(8'h11 + i)})
            $display("[TB] FAIL b2b rw[%0d]: got %0d/%h, expected 7/%h", i, bs_if.usedw_o, bs_if.q_o, 8'(8'h11 + i));
         else passed++;
      end
      bs_if.wrreq_i = 1'b0;
      for (int j = 0; j < 6; j++) begin
         cyc();
         total++; if ({bs_if.usedw_o, bs_if.q_o} !== {5'(6 - j), 8'(8'h25 + j)})
            $display("[TB] FAIL b2b drain[%0d]: got %0d/%h, expected %0d/%h", j, bs_if.usedw_o, bs_if.q_o, 6 - j, 8'(8'h25 + j));
         else passed++;
      end
      cyc();
      total++; if ({bs_if.usedw_o, bs_if.empty_o} !== {5'd0, 1'b1}) $display("[TB] FAIL b2b empty: got %0d/%b, expected 0/1", bs_if.usedw_o, bs_if.empty_o); else passed++;
      cyc();
      bs_if.rdreq_i = 1'b0;
      total++; if ({bs_if.usedw_o, bs_if.udf_o} !== {5'd0, ERR_EN}) $display("[TB] FAIL sa udf: got %0d/%b, expected 0/%b", bs_if.usedw_o, bs_if.udf_o, ERR_EN); else passed++;
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < 5; i++) begin
         bs_if.data_i = 8'(8'h50 + i); bs_if.wrreq_i = 1'b1;
         cyc();
      end
      total++; if (bs_if.usedw_o !== 5'd5) $display("[TB] FAIL mid usedw pre: got %0d, expected 5", bs_if.usedw_o); else passed++;
      bs_if.data_i = 8'h77;
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (bs_if.usedw_o !== 5'd0) $display("[TB] FAIL mid usedw: got %0d, expected 0", bs_if.usedw_o); else passed++;
      total++; if (bs_if.q_o !== 8'h00) $display("[TB] FAIL mid q: got %h, expected 00", bs_if.q_o); else passed++;
      total++; if ({bs_if.empty_o, bs_if.full_o, bs_if.almost_empty_o, bs_if.almost_full_o, bs_if.ovf_o, bs_if.udf_o} !== 6'b101000)
         $display("[TB] FAIL mid sa flags: got %b, expected 101000", {bs_if.empty_o, bs_if.full_o, bs_if.almost_empty_o, bs_if.almost_full_o, bs_if.ovf_o, bs_if.udf_o});
      else passed++;
      total++; if ({bn_if.ovf_o, bn_if.udf_o} !== 2'b00) $display("[TB] FAIL mid norm err: got %b, expected 00", {bn_if.ovf_o, bn_if.udf_o}); else passed++;
      @(posedge clk);
      bs_if.wrreq_i = 1'b0;
      #3;
      rst_n = 1'b1;
      cyc();
      total++; if ({bs_if.usedw_o, bs_if.empty_o} !== {5'd0, 1'b1}) $display("[TB] FAIL mid release: got %0d/%b, expected 0/1", bs_if.usedw_o, bs_if.empty_o); else passed++;
      bs_if.data_i = 8'h99; bs_if.wrreq_i = 1'b1;
      cyc();
      bs_if.wrreq_i = 1'b0;
      cyc();
      cyc();
      total++; if ({bs_if.q_o, bs_if.usedw_o, bs_if.empty_o} !== {8'h99, 5'd1, 1'b0})
         $display("[TB] FAIL mid rewrite: got %h/%0d/%b, expected 99/1/0", bs_if.q_o, bs_if.usedw_o, bs_if.empty_o);
      else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_fill_drain();
      test_boundary();
      test_showahead();
      test_back_to_back();
      test_reset_midstream();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
